// File: rtl/stage23_batch_scheduler_if.sv
// Requester-side valid/ready/data bundle for the stage-2/3 batch scheduler.
// One lane per requester; lane i occupies req_data[i*DATA_W +: DATA_W].
interface stage23_batch_scheduler_if #(
    parameter int DATA_W = 264,
    parameter int N_REQ  = 4
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/stage23_batch_scheduler.sv
// Round-robin packer of up to three original messages per encoder issue,
// with timeout/flush of partial batches and a post-issue idle gap.
module stage23_batch_scheduler #(
    parameter int DATA_W  = 264,
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16,
    parameter int MIN_GAP = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    stage23_batch_scheduler_if.slave  req,
    input  logic                      flush,
    output logic [DATA_W-1:0]         original_data_1,
    output logic [DATA_W-1:0]         original_data_2,
    output logic [DATA_W-1:0]         original_data_3,
    output logic                      message_en_out,
    output logic [1:0]                batch_slots,
    output logic [15:0]               batch_cnt,
    output logic                      busy
);
    typedef enum logic [1:0] {IDLE, FILL, ISSUE, GAP} state_t;

    localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMAX = (TIMEOUT > MIN_GAP) ? TIMEOUT : MIN_GAP;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] G_LAST = TW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

    state_t            state, state_n;
    logic [PW-1:0]     rr_ptr, gnt_idx, cand;
    logic              gnt_any, can_gnt, xfer;
    logic [TW-1:0]     timer;
    logic [1:0]        slot_cnt, cnt_n;
    logic [DATA_W-1:0] slot_0, slot_1, slot_2;
    logic [DATA_W-1:0] gnt_data;

    // First valid requester at or above rr_ptr, wrapping.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (int'(rr_ptr) + k >= N_REQ)
                cand = PW'(int'(rr_ptr) + k - N_REQ);
            else
                cand = PW'(int'(rr_ptr) + k);
            if (!gnt_any && req.req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign gnt_data = req.req_data[gnt_idx*DATA_W +: DATA_W];
    assign cnt_n    = slot_cnt + {1'b0, xfer};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (xfer) state_n = FILL;
            FILL:  if (cnt_n == 2'd3 || flush || timer == T_LAST)
                       state_n = ISSUE;
            ISSUE: state_n = (MIN_GAP > 0) ? GAP : IDLE;
            GAP:   if (timer == G_LAST) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        can_gnt       = (state == IDLE || state == FILL) && slot_cnt != 2'd3;
        xfer          = can_gnt && gnt_any;
        busy          = (state != IDLE);
        req.req_ready = '0;
        if (xfer) req.req_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr          <= '0;
            timer           <= '0;
            slot_cnt        <= '0;
            slot_0          <= '0;
            slot_1          <= '0;
            slot_2          <= '0;
            original_data_1 <= '0;
            original_data_2 <= '0;
            original_data_3 <= '0;
            message_en_out  <= 1'b0;
            batch_slots     <= '0;
            batch_cnt       <= '0;
        end else begin
            message_en_out <= 1'b0;
            unique case (state)
                IDLE, FILL: begin
                    timer <= (state == IDLE) ? '0 : timer + 1'b1;
                    if (xfer) begin
                        if (slot_cnt == 2'd0)      slot_0 <= gnt_data;
                        else if (slot_cnt == 2'd1) slot_1 <= gnt_data;
                        else                       slot_2 <= gnt_data;
                        slot_cnt <= cnt_n;
                        rr_ptr   <= (gnt_idx == PW'(N_REQ - 1)) ?
                                    '0 : gnt_idx + 1'b1;
                    end
                end
                ISSUE: begin
                    original_data_1 <= slot_0;
                    original_data_2 <= slot_1;
                    original_data_3 <= slot_2;
                    message_en_out  <= 1'b1;
                    batch_slots     <= slot_cnt;
                    batch_cnt       <= batch_cnt + 16'd1;
                    slot_0          <= '0;
                    slot_1          <= '0;
                    slot_2          <= '0;
                    slot_cnt        <= '0;
                    timer           <= '0;
                end
                GAP: timer <= timer + 1'b1;
                default: timer <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_stage23_batch_scheduler.sv
// Scoreboard bench for stage23_batch_scheduler: queued requesters,
// expected batches pushed at stimulus time and popped on each strobe.
module tb_stage23_batch_scheduler;
    localparam int DW = 264;
    localparam int NR = 4;
    localparam int TO = 16;
    localparam int MG = 2;

    typedef logic [DW-1:0] word_t;
    typedef struct {
        word_t      d1;
        word_t      d2;
        word_t      d3;
        logic [1:0] slots;
    } batch_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    word_t       od1, od2, od3;
    logic        men;
    logic [1:0]  bslots;
    logic [15:0] bcnt;
    logic        busy;

    stage23_batch_scheduler_if #(.DATA_W(DW), .N_REQ(NR)) rif ();

    stage23_batch_scheduler #(
        .DATA_W(DW), .N_REQ(NR), .TIMEOUT(TO), .MIN_GAP(MG)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (rif),
        .flush           (flush),
        .original_data_1 (od1),
        .original_data_2 (od2),
        .original_data_3 (od3),
        .message_en_out  (men),
        .batch_slots     (bslots),
        .batch_cnt       (bcnt),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_errors = 0;
    word_t       rq [NR][$];
    batch_t      sb [$];
    int          grants [$];
    int          xfer_edges [$];
    int          strobe_edges [$];
    logic        pend;
    int          pend_idx;
    logic        flush_req;
    logic [15:0] exp_cnt;
    word_t       last1, last2, last3;
    word_t       rr_msg [NR][6];
    word_t       a, b, c, m [6];
    int          cnt [NR];

    task automatic check(input string tag, input word_t obs, input word_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic word_t rw();
        word_t w;
        w = '0;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        w[DW-1 -: 8] = 8'($urandom);
        w[0] = 1'b1;
        return w;
    endfunction

    function automatic batch_t mkb(word_t x, word_t y, word_t z, logic [1:0] s);
        batch_t r;
        r.d1 = x; r.d2 = y; r.d3 = z; r.slots = s;
        return r;
    endfunction

    task automatic step();
        batch_t e;
        @(negedge clk);
        if (men) begin
            check("strobe_expected", word_t'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("data1", od1, e.d1);
                check("data2", od2, e.d2);
                check("data3", od3, e.d3);
                check("slots", word_t'(bslots), word_t'(e.slots));
                exp_cnt = exp_cnt + 16'd1;
                check("batch_cnt", word_t'(bcnt), word_t'(exp_cnt));
                strobe_edges.push_back(cyc);
            end
            last1 = od1; last2 = od2; last3 = od3;
        end else begin
            check("hold1", od1, last1);
            check("hold2", od2, last2);
            check("hold3", od3, last3);
        end
        if (pend) begin
            void'(rq[pend_idx].pop_front());
            pend = 1'b0;
        end
        for (int i = 0; i < NR; i++) begin
            rif.req_valid[i] = (rq[i].size() > 0);
            rif.req_data[i*DW +: DW] = (rq[i].size() > 0) ? rq[i][0] : '0;
        end
        flush = flush_req;
        flush_req = 1'b0;
        #1;
        check("ready_onehot", word_t'($onehot0(rif.req_ready)), 1);
        check("ready_subset", word_t'((rif.req_ready & ~rif.req_valid) == '0), 1);
        for (int i = 0; i < NR; i++) begin
            if (rif.req_valid[i] && rif.req_ready[i]) begin
                pend = 1'b1;
                pend_idx = i;
                grants.push_back(i);
                xfer_edges.push_back(cyc + 1);
            end
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            step();
            n++;
        end
        check(tag, word_t'(sb.size()), 0);
        sb.delete();
    endtask

    task automatic clear_logs();
        grants.delete();
        xfer_edges.delete();
        strobe_edges.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        flush_req = 1'b0;
        pend = 1'b0;
        pend_idx = 0;
        exp_cnt = '0;
        last1 = '0; last2 = '0; last3 = '0;
        rif.req_valid = '0;
        rif.req_data = '0;
        repeat (3) @(negedge clk);
        check("rst_men", word_t'(men), 0);
        check("rst_d1", od1, 0);
        check("rst_cnt", word_t'(bcnt), 0);
        check("rst_busy", word_t'(busy), 0);
        rst_n = 1'b1;

        // Round robin: all four requesters continuously valid
        clear_logs();
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < 6; k++) begin
                rr_msg[r][k] = rw();
                rq[r].push_back(rr_msg[r][k]);
            end
        for (int bi = 0; bi < 8; bi++)
            sb.push_back(mkb(rr_msg[(3*bi) % 4][(3*bi) / 4],
                             rr_msg[(3*bi+1) % 4][(3*bi+1) / 4],
                             rr_msg[(3*bi+2) % 4][(3*bi+2) / 4], 2'd3));
        drain("rr_drain", 400);
        check("rr_ngrants", word_t'(grants.size()), 24);
        for (int r = 0; r < NR; r++) cnt[r] = 0;
        for (int g = 0; g < grants.size() && g < 24; g++) begin
            check("rr_grant", word_t'(grants[g]), word_t'(g % 4));
            cnt[grants[g]]++;
        end
        for (int r = 0; r < NR; r++) check("rr_fair", word_t'(cnt[r]), 6);
        for (int i = 1; i < strobe_edges.size(); i++)
            check("rr_spacing", word_t'(strobe_edges[i] - strobe_edges[i-1]), 6);
        repeat (4) step();

        // Full batch from requesters 0, 1, 2 at once
        clear_logs();
        a = rw(); b = rw(); c = rw();
        rq[0].push_back(a); rq[1].push_back(b); rq[2].push_back(c);
        sb.push_back(mkb(a, b, c, 2'd3));
        drain("full_drain", 40);
        check("full_ngrants", word_t'(grants.size()), 3);
        if (grants.size() >= 3 && strobe_edges.size() >= 1) begin
            for (int g = 0; g < 3; g++)
                check("full_grant", word_t'(grants[g]), word_t'(g));
            check("full_consec1", word_t'(xfer_edges[1] - xfer_edges[0]), 1);
            check("full_consec2", word_t'(xfer_edges[2] - xfer_edges[1]), 1);
            check("full_latency", word_t'(strobe_edges[0] - xfer_edges[2]), 1);
        end
        repeat (4) step();

        // Reset in FILL with two slots held
        clear_logs();
        rq[0].push_back(rw()); rq[1].push_back(rw());
        for (int n = 0; n < 10 && grants.size() < 2; n++) step();
        step();
        check("mid_busy", word_t'(busy), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_men", word_t'(men), 0);
        check("mid_rst_d1", od1, 0);
        check("mid_rst_d2", od2, 0);
        check("mid_rst_d3", od3, 0);
        check("mid_rst_slots", word_t'(bslots), 0);
        check("mid_rst_cnt", word_t'(bcnt), 0);
        check("mid_rst_busy", word_t'(busy), 0);
        exp_cnt = '0;
        last1 = '0; last2 = '0; last3 = '0;
        pend = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) step();
        check("post_rst_busy", word_t'(busy), 0);

        // Timeout of a single message from requester 3
        clear_logs();
        a = rw();
        rq[3].push_back(a);
        sb.push_back(mkb(a, '0, '0, 2'd1));
        drain("tmo_drain", 40);
        if (strobe_edges.size() >= 1 && xfer_edges.size() >= 1)
            check("tmo_latency", word_t'(strobe_edges[0] - xfer_edges[0]), TO + 1);
        repeat (4) step();

        // Flush after two messages
        clear_logs();
        a = rw(); b = rw();
        rq[0].push_back(a); rq[1].push_back(b);
        sb.push_back(mkb(a, b, '0, 2'd2));
        for (int n = 0; n < 10 && grants.size() < 2; n++) step();
        flush_req = 1'b1;
        step();
        drain("flush_drain", 10);
        if (strobe_edges.size() >= 1 && xfer_edges.size() >= 2)
            check("flush_latency", word_t'(strobe_edges[0] - xfer_edges[1]), 2);
        repeat (4) step();

        // Flush while idle must not issue
        check("idle_busy", word_t'(busy), 0);
        flush_req = 1'b1;
        repeat (8) step();
        check("idle_flush_busy", word_t'(busy), 0);
        check("idle_flush_cnt", word_t'(bcnt), word_t'(exp_cnt));

        // Counter wrap with one requester streaming six messages
        @(negedge clk);
        force dut.batch_cnt = 16'hFFFE;
        #1;
        release dut.batch_cnt;
        exp_cnt = 16'hFFFE;
        for (int i = 0; i < 6; i++) begin
            m[i] = rw();
            rq[1].push_back(m[i]);
        end
        sb.push_back(mkb(m[0], m[1], m[2], 2'd3));
        sb.push_back(mkb(m[3], m[4], m[5], 2'd3));
        drain("wrap_drain", 60);
        repeat (6) step();
        check("wrap_cnt", word_t'(bcnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
